// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control FSM for the RV32I core. Each instruction steps
//   through FETCH/DECODE/EXEC/MEM/WB and the block emits one-cycle enables
//   for the instruction register, PC, register file and unified memory.
//
//   Optional feature macro: RETIRE_CNT_EN (retired-instruction counter).
//
// Ports
//   CLK          core clock, rising edge
//   RST_N        asynchronous active-low reset
//   INSN[31:0]   instruction register contents (valid from DECODE onward)
//   br_taken     branch comparison result, sampled in EXEC
//   mem_ready    memory completes the current access this cycle
//   mem_req      memory access request
//   mem_we       store enable (only with mem_req)
//   ir_load      latch memory read data into the instruction register
//   addr_sel     memory address: 0 = PC, 1 = ALU result
//   pc_next_sel  next PC: 0 = PC adder, 1 = ALU
//   pc_alu_sel   PC adder operand: 0 = +4, 1 = immediate
//   sub_sra      ALU subtract / arithmetic shift
//   pc_load      PC write enable
//   rd_we        register file write enable
//   state[2:0]   current state encoding
//   halted       core trapped
//   instret[31:0] retired-instruction count (0 without RETIRE_CNT_EN)
//
// state  | meaning
// FETCH  | read instruction at PC, wait for mem_ready
// DECODE | classify opcode; FENCE retires here
// EXEC   | ALU operation; BRANCH retires here
// MEM    | load/store data access, wait for mem_ready
// WB     | register write-back and PC update
// TRAP   | sticky halt, exit only through reset
module multicycle_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] INSN,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_load,
  output logic        addr_sel,
  output logic        pc_next_sel,
  output logic        pc_alu_sel,
  output logic        sub_sra,
  output logic        pc_load,
  output logic        rd_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // Last counter value before the timeout fires; unused when timeout is off.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           st;
  logic [CNT_W-1:0] wait_cnt;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             exec_op;
  logic             wait_expired;
  logic             unused_insn;

  assign opcode = INSN[6:0];
  assign funct3 = INSN[14:12];
  assign unused_insn = ^{INSN[31], INSN[29:15], INSN[11:7]};

  always_comb begin
    exec_op = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OPIMM,
      OP_OP, OP_LOAD, OP_STORE, OP_BRANCH: exec_op = 1'b1;
      default: exec_op = 1'b0;
    endcase
  end

  // The cycle that would bring the count to TIMEOUT_CYCLES traps instead.
  assign wait_expired = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st       <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (st)
        S_FETCH: begin
          if (mem_ready) begin
            st <= S_DECODE;
          end else if (wait_expired) begin
            st <= S_TRAP;
          end else if (TIMEOUT_CYCLES != 0) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          if (exec_op)                st <= S_EXEC;
          else if (opcode == OP_FENCE) st <= S_FETCH;
          else                        st <= S_TRAP;
        end
        S_EXEC: begin
          if (opcode == OP_BRANCH)                          st <= S_FETCH;
          else if (opcode == OP_LOAD || opcode == OP_STORE) st <= S_MEM;
          else                                              st <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            st <= (opcode == OP_STORE) ? S_FETCH : S_WB;
          end else if (wait_expired) begin
            st <= S_TRAP;
          end else if (TIMEOUT_CYCLES != 0) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_WB:    st <= S_FETCH;
        S_TRAP:  st <= S_TRAP;
        default: st <= S_TRAP;
      endcase
    end
  end

  // Outputs are forced low while reset is held so nothing is driven to
  // the datapath or memory until the core is released.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_load     = 1'b0;
    addr_sel    = 1'b0;
    pc_next_sel = 1'b0;
    pc_alu_sel  = 1'b0;
    sub_sra     = 1'b0;
    pc_load     = 1'b0;
    rd_we       = 1'b0;
    if (RST_N) begin
      case (st)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_load = mem_ready;
        end
        S_DECODE: begin
          pc_load = (opcode == OP_FENCE);
        end
        S_EXEC: begin
          case (opcode)
            OP_OP:     sub_sra = INSN[30] && (funct3 == 3'b000 || funct3 == 3'b101);
            OP_OPIMM:  sub_sra = INSN[30] && (funct3 == 3'b101);
            OP_BRANCH: begin
              sub_sra    = 1'b1;
              pc_load    = 1'b1;
              pc_alu_sel = br_taken;
            end
            default:   sub_sra = 1'b0;
          endcase
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode == OP_STORE);
          pc_load  = (opcode == OP_STORE) && mem_ready;
        end
        S_WB: begin
          rd_we       = 1'b1;
          pc_load     = 1'b1;
          pc_next_sel = (opcode == OP_JALR);
          pc_alu_sel  = (opcode == OP_JAL);
        end
        default: ;
      endcase
    end
  end

  assign state  = st;
  assign halted = (st == S_TRAP);

`ifdef RETIRE_CNT_EN
  logic [31:0] ret_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       ret_cnt <= '0;
    else if (pc_load) ret_cnt <= ret_cnt + 32'd1;
  end

  assign instret = ret_cnt;
`else
  assign instret = '0;
`endif

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath selects (addr_sel, pc_next_sel, pc_alu_sel, sub_sra) and the write strobes.
- Handshakes with the unified memory through mem_req/mem_ready.
- Sits between the instruction register, datapath and memory; replaces per-format clock gating with explicit one-cycle enables.

Parameters:
- TIMEOUT_CYCLES, 16: maximum wait cycles for mem_ready before trapping; 0 disables the timeout.
- CNT_W, 5: width of the internal wait counter; must hold TIMEOUT_CYCLES.

Ports:
- CLK  in  1  core clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- INSN  in  32  instruction register contents; valid from DECODE onward.
- br_taken  in  1  branch comparison result from the ALU; valid in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  store enable; only asserted together with mem_req.
- ir_load  out  1  latch the memory read data into INSN.
- addr_sel  out  1  memory address select: 0 = PC, 1 = ALU result.
- pc_next_sel  out  1  next-PC select: 0 = PC adder, 1 = ALU (jump target).
- pc_alu_sel  out  1  PC adder operand: 0 = +4, 1 = immediate.
- sub_sra  out  1  ALU subtract / arithmetic-shift control.
- pc_load  out  1  PC write enable.
- rd_we  out  1  register file write enable.
- state  out  3  current state encoding.
- halted  out  1  core trapped.
- instret  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (RST_N low, asynchronous):
  - State goes to FETCH; the wait counter and instret clear.
  - All strobes and selects are 0; halted = 0.
  - Reset mid-access abandons the access; no pc_load or rd_we is issued.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- All outputs are decoded from the registered state plus INSN; no output depends combinationally on mem_ready, except ir_load and pc_load on the completion cycle.
- FETCH:
  - mem_req=1, addr_sel=0, mem_we=0.
  - When mem_ready=1: ir_load=1 for that cycle, then go to DECODE.
  - Each cycle with mem_ready=0 increments the wait counter. When it reaches TIMEOUT_CYCLES (if nonzero), go to TRAP.
  - The counter clears on every state change.
- DECODE (1 cycle), branching on opcode INSN[6:0]:
  - 0110111, 0010111, 1101111, 1100111, 0010011, 0110011, 0000011, 0100011, 1100011 go to EXEC.
  - 0001111 (FENCE) is a NOP: pc_load=1 with pc_next_sel=0 and pc_alu_sel=0, then FETCH.
  - 1110011 (SYSTEM) and any other opcode go to TRAP.
- EXEC (1 cycle):
  - sub_sra = 1 for OP when INSN[30]=1 and funct3 is 000 or 101.
  - sub_sra = 1 for OP-IMM when INSN[30]=1 and funct3=101.
  - sub_sra = 1 for BRANCH.
  - sub_sra = 0 for everything else.
  - BRANCH: pc_load=1, pc_next_sel=0, pc_alu_sel=br_taken, then FETCH.
  - LOAD and STORE go to MEM; all other opcodes go to WB.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=1 for STORE only; held until mem_ready.
  - The timeout rule is the same as in FETCH.
  - STORE: on mem_ready, pc_load=1 (PC+4), then FETCH.
  - LOAD: on mem_ready, go to WB.
- WB (1 cycle):
  - rd_we=1 and pc_load=1.
  - JAL: pc_next_sel=0, pc_alu_sel=1.
  - JALR: pc_next_sel=1, pc_alu_sel=0.
  - Others: pc_next_sel=0, pc_alu_sel=0.
  - Then FETCH.
- TRAP:
  - Sticky; halted=1; all strobes 0.
  - Only reset exits this state.
- Latency with zero-wait memory: FENCE 2, BRANCH 3, STORE and ALU/JAL/JALR/LUI/AUIPC 4, LOAD 5 cycles.
- Exactly one pc_load pulse per retired instruction; never more than one rd_we pulse per instruction.

Optional Feature:
- Macro: RETIRE_CNT_EN.
- Defined: instret increments by 1 on every cycle with pc_load=1. It wraps from 0xFFFFFFFF to 0 and clears on reset.
- Undefined: instret is tied to 0 and no counter is synthesized.

Test Plan:
- ADDI x1,x0,5 (0x00500093), zero-wait memory -> states 0,1,2,4. rd_we and pc_load high only in cycle 4; sub_sra=0; instret=1.
- SW x1,0(x0) (0x00102023), mem_ready delayed 3 cycles in MEM -> mem_req=mem_we=addr_sel=1 for 4 cycles. pc_load only on the ready cycle; rd_we never asserted.
- LW x2,0(x0) (0x00002103) -> 5 cycles; MEM has addr_sel=1, mem_we=0; rd_we in WB.
- BEQ x0,x0,8 (0x00000463) with br_taken=1, then br_taken=0 -> 3 cycles each; pc_alu_sel=1 then 0; sub_sra=1 in EXEC.
- JALR x1,0(x2) (0x000100E7) -> WB shows pc_next_sel=1, rd_we=1. SUB (0x40208033) -> sub_sra=1 in EXEC.
- Three separate runs, each ending in TRAP:
  - INSN 0xFFFFFFFF -> TRAP, halted=1.
  - ECALL (0x00000073) -> TRAP, halted=1.
  - mem_ready held low 16 cycles in FETCH -> TRAP.
  - After any of these, RST_N pulsed low mid-cycle -> immediate FETCH, halted=0.
